nr4sdp_seq_mult: RTL and testbench
==================================

NR4SDP_SEQ_MULT -- requirements
Module: nr4sdp_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32, multiplicand/multiplier width; only 32 is supported.
REQ-002 SHALL have parameter NDIG, default 16, number of radix-4 digits (15 NR4SDP digits plus 1 MB digit).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port x  in  32  signed two's-complement multiplicand.
REQ-006 SHALL have port nm  in  15  NR4SDP negative-sum bits from the upstream encoder, digit j = nm[j].
REQ-007 SHALL have port np  in  15  NR4SDP positive-sum bits, digit j = np[j].
REQ-008 SHALL have ports sign, one, two  in  1 each  MB encoding of the top digit (j=15).
REQ-009 SHALL have port in_valid  in  1  operands valid.
REQ-010 SHALL have port in_ready  out  1  block can accept operands.
REQ-011 SHALL have port product  out  64  signed product x*multiplier.
REQ-012 SHALL have port out_valid  out  1  product valid.
REQ-013 SHALL have port out_ready  in  1  consumer accepts product.

Function
REQ-014 SHALL decode NR4SDP digit j (0..14) as d_j = 2*np[j] - nm[j]: (0,0)=0, nm only=-1, np only=+2, both=+1.
REQ-015 SHALL decode the top digit as d_15 = (sign ? -1 : +1) * (one ? 1 : two ? 2 : 0); one has priority over two; sign with zero magnitude gives 0.
REQ-016 SHALL compute product = sum over j=0..15 of d_j * x * 4^j, exact in 64-bit two's complement for all 32-bit signed operands.
REQ-017 SHALL form each partial product as d_j*x sign-extended to 64 bits, shifted left by 2j; accumulation modulo 2^64.
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture x, nm, np, sign, one, two, clear accumulator and digit counter, go to RUN.
REQ-020 RUN: in_ready=0; exactly one digit per clock in order j=0..15; counter 4 bits; on the edge processing j=15, go to DONE.
REQ-021 SHALL assert out_valid on the 16th rising edge after the accepting edge (latency 16 cycles).
REQ-022 DONE: out_valid=1, in_ready=0, product stable; on out_valid&&out_ready go to IDLE with out_valid=0 after that edge.
REQ-023 SHALL ignore in_valid and input changes outside IDLE; captured operands only are used.
REQ-024 SHALL hold product indefinitely while out_ready=0.
REQ-025 product SHALL retain the last result in IDLE until the next acceptance clears the accumulator.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, in_ready=1, out_valid=0, product=0, counter=0, operand registers=0.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no out_valid pulse; first operation after release SHALL be correct.

Structure
REQ-028 Package nr4sdp_pkg SHALL hold WIDTH, NDIG, product width (64) and the state encoding constants.
REQ-029 SHALL contain one sub-module nr4sdp_pp_gen: combinational, inputs x and the selected digit controls, output 64-bit sign-extended d_j*x.
REQ-030 Digit selection, counter, accumulator and FSM SHALL reside in nr4sdp_seq_mult.

Verification
REQ-031 x=3, nm=15'h0003, np=15'h0003, sign/one/two=0/0/0 (multiplier 5) -> product 64'h000000000000000F, out_valid 16 cycles after acceptance.
REQ-032 x=7, nm=15'h0001, np=15'h0000, sign/one/two=0/0/0 (multiplier -1) -> product 64'hFFFFFFFFFFFFFFF9.
REQ-033 x=32'h80000000, nm=np=0, sign/one/two=1/0/1 (multiplier -2^31) -> product 64'h4000000000000000.
REQ-034 out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands -> product unchanged, in_ready=0, no acceptance; out_ready=1 -> IDLE next edge.
REQ-035 rst_n pulsed low while processing digit 7 -> out_valid=0, in_ready=1 immediately; next operation per REQ-031 yields 64'h000000000000000F.
REQ-036 x=5, nm=np=0, sign/one/two=0/1/1 -> top digit treated as +1, product 5*4^15 = 64'h0000000140000000.

Source files
------------

// File: rtl/nr4sdp_pkg.sv
// nr4sdp_pkg
//   Shared constants and the FSM state type for the sequential radix-4
//   NR4SDP/MB multiplier (nr4sdp_seq_mult and nr4sdp_pp_gen).
package nr4sdp_pkg;

    localparam int WIDTH  = 32;            // multiplicand / multiplier width
    localparam int NDIG   = 16;            // radix-4 digits: 15 NR4SDP + 1 MB
    localparam int PWIDTH = 2 * WIDTH;     // product width (64)
    localparam int CNT_W  = $clog2(NDIG);  // digit counter width (4)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nr4sdp_pp_gen.sv
// nr4sdp_pp_gen
//   Combinational partial-product generator: pp = d * x, sign-extended to
//   PWIDTH bits, where d is in {-2,-1,0,+1,+2} given as sign/magnitude
//   controls.
// Ports
//   x    in  WIDTH   signed multiplicand
//   neg  in  1       digit is negative
//   one  in  1       |d| = 1 (has priority over two)
//   two  in  1       |d| = 2
//   pp   out PWIDTH  d * x, two's complement
module nr4sdp_pp_gen
    import nr4sdp_pkg::*;
(
    input  logic [WIDTH-1:0]  x,
    input  logic              neg,
    input  logic              one,
    input  logic              two,
    output logic [PWIDTH-1:0] pp
);

    logic [PWIDTH-1:0] sx;
    logic [PWIDTH-1:0] mag;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first); otherwise synthesis infers a latch.
    always_comb begin
        sx  = {{(PWIDTH-WIDTH){x[WIDTH-1]}}, x};
        mag = '0;
        if (one)      mag = sx;
        else if (two) mag = sx << 1;
        pp  = neg ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/nr4sdp_seq_mult.sv
// nr4sdp_seq_mult
//   Sequential signed 32x32 multiplier consuming a pre-encoded multiplier:
//   digits 0..14 in NR4SDP form (np/nm), digit 15 in Modified-Booth form
//   (sign/one/two). One radix-4 digit per clock; product valid 16 cycles
//   after acceptance, held until out_ready.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   x                   signed multiplicand
//   nm, np              NR4SDP negative/positive bits, digit j = bit j
//   sign, one, two      MB encoding of the top digit
//   in_valid/in_ready   operand handshake
//   product             signed product (accumulator, retained in IDLE)
//   out_valid/out_ready result handshake
module nr4sdp_seq_mult #(
    parameter int WIDTH = nr4sdp_pkg::WIDTH,
    parameter int NDIG  = nr4sdp_pkg::NDIG
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     x,
    input  logic [NDIG-2:0]      nm,
    input  logic [NDIG-2:0]      np,
    input  logic                 sign,
    input  logic                 one,
    input  logic                 two,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    input  logic                 out_ready
);

    import nr4sdp_pkg::*;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [PWIDTH-1:0]   acc;
    logic [WIDTH-1:0]    x_r;
    logic [NDIG-2:0]     nm_r;
    logic [NDIG-2:0]     np_r;
    logic                sign_r;
    logic                one_r;
    logic                two_r;

    // Zero-extended to NDIG bits so indexing by the full counter stays in range.
    logic [NDIG-1:0]     nm_e;
    logic [NDIG-1:0]     np_e;
    logic                dig_neg;
    logic                dig_one;
    logic                dig_two;
    logic [PWIDTH-1:0]   pp;
    logic [PWIDTH-1:0]   pp_shift;

    assign nm_e = {1'b0, nm_r};
    assign np_e = {1'b0, np_r};

    // Map the current digit onto neg/one/two controls.
    // NR4SDP: (np,nm) = 00 -> 0, 01 -> -1, 10 -> +2, 11 -> +1.
    // MB top digit: one beats two; a sign with zero magnitude is +0.
    always_comb begin
        dig_neg = 1'b0;
        dig_one = 1'b0;
        dig_two = 1'b0;
        if (cnt == CNT_W'(NDIG-1)) begin
            dig_one = one_r;
            dig_two = two_r & ~one_r;
            dig_neg = sign_r & (one_r | two_r);
        end else begin
            dig_one = nm_e[cnt];
            dig_two = np_e[cnt] & ~nm_e[cnt];
            dig_neg = nm_e[cnt] & ~np_e[cnt];
        end
    end

    nr4sdp_pp_gen u_pp_gen (
        .x   (x_r),
        .neg (dig_neg),
        .one (dig_one),
        .two (dig_two),
        .pp  (pp)
    );

    // Weight 4^j: shift by 2*cnt.
    assign pp_shift = pp << {cnt, 1'b0};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    // The operand registers are plain flops (not a memory array), so they are
    // cleared by the asynchronous reset along with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            x_r       <= '0;
            nm_r      <= '0;
            np_r      <= '0;
            sign_r    <= 1'b0;
            one_r     <= 1'b0;
            two_r     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_r      <= x;
                        nm_r     <= nm;
                        np_r     <= np;
                        sign_r   <= sign;
                        one_r    <= one;
                        two_r    <= two;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc + pp_shift;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NDIG-1)) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_nr4sdp_seq_mult.sv
// tb_nr4sdp_seq_mult
//   Self-checking bench: expected products are computed from the operand
//   digits by a direct multiplier reconstruction, queued at acceptance and
//   compared when out_valid rises.
module tb_nr4sdp_seq_mult;

    logic        clk;
    logic        rst_n;
    logic [31:0] x;
    logic [14:0] nm;
    logic [14:0] np;
    logic        sign;
    logic        one;
    logic        two;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] product;
    logic        out_valid;
    logic        out_ready;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];

    nr4sdp_seq_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .nm        (nm),
        .np        (np),
        .sign      (sign),
        .one       (one),
        .two       (two),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Multiplier value rebuilt from the digit encodings, then multiplied.
    function automatic logic [63:0] model(input logic [31:0] xv, input logic [14:0] nmv,
                                          input logic [14:0] npv, input logic s,
                                          input logic o, input logic t);
        longint m;
        longint d;
        longint mag;
        m = 0;
        for (int j = 0; j < 15; j++) begin
            d = 2 * longint'(npv[j]) - longint'(nmv[j]);
            m += d <<< (2 * j);
        end
        mag = o ? 64'sd1 : (t ? 64'sd2 : 64'sd0);
        d   = s ? -mag : mag;
        m  += d <<< 30;
        return 64'(longint'($signed(xv)) * m);
    endfunction

    task automatic scramble_inputs();
        x    = $urandom;
        nm   = 15'($urandom);
        np   = 15'($urandom);
        sign = 1'($urandom);
        one  = 1'($urandom);
        two  = 1'($urandom);
    endtask

    task automatic run_op(input logic [31:0] xv, input logic [14:0] nmv, input logic [14:0] npv,
                          input logic s, input logic o, input logic t, input int stall);
        int          cyc;
        logic [63:0] held;
        logic [63:0] expv;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        x = xv; nm = nmv; np = npv; sign = s; one = o; two = t;
        in_valid = 1'b1;
        sb_q.push_back(model(xv, nmv, npv, s, o, t));
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        check("in_ready_run", 64'(in_ready), 64'd0);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'd16);
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 64'd1, 64'd0);
            end else begin
                expv = sb_q.pop_front();
                check("product", product, expv);
            end
        end
        held = product;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            scramble_inputs();
            @(posedge clk); #1;
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_product", product, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
        check("product_retain", product, held);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_valid;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; nm = '0; np = '0; sign = 1'b0; one = 1'b0; two = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(32'd3, 15'h0003, 15'h0003, 1'b0, 1'b0, 1'b0, 0);
        check("dir_mult5", product, 64'h000000000000000F);
        run_op(32'd7, 15'h0001, 15'h0000, 1'b0, 1'b0, 1'b0, 1);
        check("dir_minus1", product, 64'hFFFFFFFFFFFFFFF9);
        run_op(32'h80000000, 15'h0000, 15'h0000, 1'b1, 1'b0, 1'b1, 0);
        check("dir_min_sq", product, 64'h4000000000000000);
        run_op(32'd5, 15'h0000, 15'h0000, 1'b0, 1'b1, 1'b1, 0);
        check("dir_one_prio", product, 64'h0000000140000000);
        run_op(32'h12345678, 15'h5A5A, 15'h3C3C, 1'b1, 1'b0, 1'b0, 5);
        run_op(32'hFFFFFFFF, 15'h7FFF, 15'h7FFF, 1'b1, 1'b1, 1'b0, 2);

        // Reset while digit 7 is being processed
        @(negedge clk);
        x = 32'd3; nm = 15'h0003; np = 15'h0003; sign = 1'b0; one = 1'b0; two = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_pulse", 64'(saw_valid), 64'd0);
        run_op(32'd3, 15'h0003, 15'h0003, 1'b0, 1'b0, 1'b0, 0);
        check("post_reset_mult5", product, 64'h000000000000000F);

        // Random operands
        for (int k = 0; k < 8; k++) begin
            run_op($urandom, 15'($urandom), 15'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)));
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
